router_sync_n: RTL and testbench

- Parametrised write-side synchroniser for an N-output packet router.
- Latches the destination address when the FSM signals detect_add, then:
  - steers the FSM write strobe to the addressed output FIFO (one-hot);
  - returns that FIFO's full flag to the FSM;
  - drives per-port valid_out from FIFO empty flags.
- Per-port read-timeout watchdog issues a one-cycle soft_reset to any FIFO left unread for TIMEOUT cycles.
- Flags packets addressed to a non-existent port.
- Sits between the router FSM and the N output FIFOs.

---
 rtl/router_sync_n.sv | 90 +++++++++
 tb/tb_router_sync_n.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_sync_n.sv
// Write-side synchroniser for an N-output packet router: latches the header
// address, steers the FSM write strobe, and watches each output for read stalls.
module router_sync_n #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2,
    parameter int TIMEOUT   = 30,
    parameter int CNT_W     = 5
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 detect_add,
    input  logic                 write_enb_reg,
    input  logic [NUM_PORTS-1:0] full,
    input  logic [NUM_PORTS-1:0] empty,
    input  logic [NUM_PORTS-1:0] read_enb,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 fifo_full,
    output logic [NUM_PORTS-1:0] vld_out,
    output logic [NUM_PORTS-1:0] soft_reset,
    output logic                 addr_err
);

    logic [ADDR_W-1:0]    addr_q;
    logic [ADDR_W-1:0]    addr_d;
    logic [NUM_PORTS-1:0] port_sel;

    always_comb begin
        addr_d = addr_q;
        if (detect_add) begin
            addr_d = data_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // One extra bit so the compare stays meaningful when 2^ADDR_W == NUM_PORTS.
    assign addr_err  = {1'b0, addr_q} >= (ADDR_W + 1)'(NUM_PORTS);
    assign fifo_full = ~addr_err & (|(full & port_sel));
    assign vld_out   = ~empty;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             sr_q;
            logic             sr_d;
            logic             stall;
            logic             expired;

            assign port_sel[gi]   = (addr_q == ADDR_W'(gi));
            assign write_enb[gi]  = write_enb_reg & ~addr_err & port_sel[gi] & ~sr_q;
            assign soft_reset[gi] = sr_q;

            assign stall   = vld_out[gi] & ~read_enb[gi];
            assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

            // The pulse cycle itself never counts toward the next timeout.
            always_comb begin
                cnt_d = '0;
                sr_d  = 1'b0;
                if (!sr_q && stall) begin
                    if (expired) begin
                        sr_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    cnt_q <= '0;
                    sr_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    sr_q  <= sr_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_router_sync_n.sv
// Self-checking bench for router_sync_n: directed vector table, hand-written
// watchdog/reset sequences, then randomized traffic against a run-length model.
module tb_router_sync_n;

    localparam int NP = 3;
    localparam int AW = 2;
    localparam int TO = 30;

    logic          clk = 1'b0;
    logic          resetn;
    logic [AW-1:0] data_in;
    logic          detect_add;
    logic          write_enb_reg;
    logic [NP-1:0] full, empty, read_enb;
    logic [NP-1:0] write_enb, vld_out, soft_reset;
    logic          fifo_full, addr_err;

    int total = 0;
    int bad   = 0;

    router_sync_n #(.NUM_PORTS(NP), .ADDR_W(AW), .TIMEOUT(TO), .CNT_W(5)) dut (
        .clock(clk), .resetn(resetn), .data_in(data_in), .detect_add(detect_add),
        .write_enb_reg(write_enb_reg), .full(full), .empty(empty), .read_enb(read_enb),
        .write_enb(write_enb), .fifo_full(fifo_full), .vld_out(vld_out),
        .soft_reset(soft_reset), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          det;
        logic [AW-1:0] din;
        logic          wer;
        logic [NP-1:0] full;
        logic [NP-1:0] empty;
        logic [NP-1:0] rd;
        logic [NP-1:0] exp_we;
        logic [NP-1:0] exp_vld;
        logic          exp_ff;
        logic          exp_err;
    } vec_t;

    vec_t vecs[12];

    // Reference model: latched address plus, per port, the length of the
    // current run of stall cycles and whether a pulse is being shown.
    int m_addr;
    int m_run[NP];
    bit m_sr[NP];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_addr = 0;
        for (int i = 0; i < NP; i++) begin
            m_run[i] = 0;
            m_sr[i]  = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        detect_add    = 1'b0;
        data_in       = '0;
        write_enb_reg = 1'b0;
        full          = '0;
        empty         = '1;
        read_enb      = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        model_clear();
    endtask

    function automatic logic [12:0] model_outputs();
        logic [NP-1:0] we, sr;
        logic          err, ff;
        err = (m_addr >= NP);
        ff  = err ? 1'b0 : full[m_addr];
        for (int i = 0; i < NP; i++) begin
            sr[i] = m_sr[i];
            we[i] = write_enb_reg && !err && (m_addr == i) && !m_sr[i];
        end
        return {1'b0, we, ff, ~empty, sr, err};
    endfunction

    task automatic model_step();
        bit stall;
        for (int i = 0; i < NP; i++) begin
            stall = !empty[i] && !read_enb[i];
            if (m_sr[i]) begin
                m_sr[i]  = 1'b0;
                m_run[i] = 0;
            end else if (stall) begin
                m_run[i]++;
                if (m_run[i] == TO) begin
                    m_sr[i]  = 1'b1;
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (detect_add) m_addr = int'(data_in);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [NP-1:0] exp_sr;
        logic [12:0]   dut_out;

        // det, din, wer, full, empty, rd, exp_we, exp_vld, exp_ff, exp_err
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 3'b100, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 3'b100, 3'b111, 3'b000, 3'b100, 3'b000, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 2'd1, 1'b0, 3'b010, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 3'b010, 3'b111, 3'b000, 3'b010, 3'b000, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 2'd3, 1'b0, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 2'd0, 1'b1, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 2'd0, 1'b0, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 2'd0, 1'b1, 3'b001, 3'b111, 3'b000, 3'b001, 3'b000, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 2'd2, 1'b1, 3'b001, 3'b111, 3'b000, 3'b001, 3'b000, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 2'd0, 1'b1, 3'b000, 3'b111, 3'b000, 3'b100, 3'b000, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 2'd0, 1'b0, 3'b100, 3'b010, 3'b111, 3'b000, 3'b101, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 2'd0, 1'b1, 3'b011, 3'b000, 3'b111, 3'b100, 3'b111, 1'b0, 1'b0};

        idle_inputs();
        resetn = 1'b1;
        #3;
        do_reset();
        check("reset_write_enb", write_enb, 3'b000);
        check("reset_soft_reset", soft_reset, 3'b000);
        check("reset_addr_err", addr_err, 1'b0);

        // Directed steering / address-error table.
        for (int v = 0; v < 12; v++) begin
            detect_add    = vecs[v].det;
            data_in       = vecs[v].din;
            write_enb_reg = vecs[v].wer;
            full          = vecs[v].full;
            empty         = vecs[v].empty;
            read_enb      = vecs[v].rd;
            #1;
            check($sformatf("vec%0d_write_enb", v), write_enb, vecs[v].exp_we);
            check($sformatf("vec%0d_vld_out", v), vld_out, vecs[v].exp_vld);
            check($sformatf("vec%0d_fifo_full", v), fifo_full, vecs[v].exp_ff);
            check($sformatf("vec%0d_addr_err", v), addr_err, vecs[v].exp_err);
            check($sformatf("vec%0d_soft_reset", v), soft_reset, 3'b000);
            $display("vector %0d applied: we=%b vld=%b ff=%b err=%b", v, write_enb, vld_out, fifo_full, addr_err);
            tick();
        end

        // Asynchronous reset mid-cycle while a pulse and an address error are live.
        do_reset();
        detect_add = 1'b1;
        data_in    = 2'd3;
        tick();
        detect_add = 1'b0;
        empty      = 3'b110;
        for (int k = 0; k < TO; k++) tick();
        #1;
        check("pre_reset_soft_reset", soft_reset, 3'b001);
        check("pre_reset_addr_err", addr_err, 1'b1);
        resetn = 1'b0;
        #1;
        check("async_reset_soft_reset", soft_reset, 3'b000);
        check("async_reset_addr_err", addr_err, 1'b0);
        check("async_reset_write_enb", write_enb, 3'b000);
        $display("async reset sequence applied");
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        // Counting must restart from zero after the aborted run.
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_reset_k%0d", k), soft_reset, (k == TO) ? 3'b001 : 3'b000);
        end
        $display("post-reset restart sequence applied");

        // Continuous stall on port 0: pulse every TIMEOUT stall cycles plus the pulse cycle.
        do_reset();
        empty = 3'b110;
        for (int k = 1; k <= 70; k++) begin
            #1;
            exp_sr = (k % (TO + 1) == 0) ? 3'b001 : 3'b000;
            check($sformatf("timeout_k%0d", k), soft_reset, exp_sr);
            tick();
        end
        $display("timeout sequence applied");

        // One read on port 1 after 29 stall cycles restarts the count.
        do_reset();
        empty = 3'b101;
        for (int k = 1; k <= 61; k++) begin
            read_enb = (k == TO) ? 3'b010 : 3'b000;
            #1;
            check($sformatf("clear_k%0d", k), soft_reset, (k == 2 * TO + 1) ? 3'b010 : 3'b000);
            tick();
        end
        $display("counter clear sequence applied");

        // Timeout on the addressed port masks its write strobe for that cycle only.
        do_reset();
        detect_add = 1'b1;
        data_in    = 2'd0;
        tick();
        detect_add    = 1'b0;
        write_enb_reg = 1'b1;
        full          = 3'b001;
        empty         = 3'b110;
        for (int k = 1; k <= 33; k++) begin
            #1;
            exp_sr = (k == TO + 1) ? 3'b001 : 3'b000;
            check($sformatf("collide_sr_k%0d", k), soft_reset, exp_sr);
            check($sformatf("collide_we_k%0d", k), write_enb, exp_sr[0] ? 3'b000 : 3'b001);
            check($sformatf("collide_ff_k%0d", k), fifo_full, 1'b1);
            tick();
        end
        $display("collision sequence applied");

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            detect_add    = ($urandom_range(0, 3) == 0);
            data_in       = AW'($urandom_range(0, 3));
            write_enb_reg = $urandom_range(0, 1) == 1;
            full          = NP'($urandom_range(0, 7));
            for (int i = 0; i < NP; i++) begin
                empty[i]    = ($urandom_range(0, 15) == 0);
                read_enb[i] = ($urandom_range(0, 39) == 0);
            end
            #1;
            dut_out = {1'b0, write_enb, fifo_full, vld_out, soft_reset, addr_err};
            check($sformatf("random_n%0d", n), dut_out, model_outputs());
            @(posedge clk);
            model_step();
            #1;
        end
        $display("random phase applied: 3000 cycles");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
